snake_dir_ctrl: RTL and testbench

Direction scheduler between the four debounced button pulses and the snake movement engine. Arbitrates simultaneous presses, rejects reversals and duplicates, and buffers up to DEPTH accepted turns. Releases exactly one turn per game tick, so fast key sequences (e.g. up-then-left inside one step) are never lost or applied as a self-collision. Sits downstream of the per-button debounce edge detectors and upstream of the snake position/update logic.

---
 rtl/snake_pkg.sv | 21 ++
 rtl/snake_dir_fifo.sv | 52 +++++
 rtl/snake_dir_ctrl.sv | 95 +++++++++
 tb/tb_snake_dir_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction and controller state definitions for the snake datapath
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    function automatic logic [1:0] opposite(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// rtl/snake_dir_fifo.sv - DEPTH-entry circular turn buffer with push/pop/flush
module snake_dir_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [1:0] din,
    output logic [2:0] count,
    output logic [1:0] head,
    output logic [1:0] tail
);

    localparam logic [1:0] LAST = 2'(DEPTH - 1);

    // Sized for the largest legal DEPTH so 2-bit pointers always index cleanly.
    logic [1:0] mem [4];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;

    function automatic logic [1:0] inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else if (flush) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop)  rd_ptr <= inc(rd_ptr);
            count <= count + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];
    assign tail = mem[(wr_ptr == 2'd0) ? LAST : wr_ptr - 2'd1];

endmodule

// File: rtl/snake_dir_ctrl.sv
// rtl/snake_dir_ctrl.sv - arbitrates button presses into a turn queue released one per game tick
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       tick,
    input  logic       halt,
    output logic [1:0] dir,
    output logic       moving,
    output logic [2:0] q_count,
    output logic       dropped
);

    state_t     state;
    logic [1:0] p;
    logic [1:0] ref_dir;
    logic [1:0] head;
    logic [1:0] tail;
    logic       press;
    logic       accept;
    logic       full;
    logic       push;
    logic       pop;

    assign press = btn_up | btn_down | btn_left | btn_right;

    always_comb begin
        p       = btn_up   ? DIR_UP   :
                  btn_down ? DIR_DOWN :
                  btn_left ? DIR_LEFT : DIR_RIGHT;
        // New turns are judged against the last queued turn, not the one on screen.
        ref_dir = (q_count != 3'd0) ? tail : dir;
        accept  = press && (p != ref_dir) && (p != opposite(ref_dir));
        full    = (q_count == 3'(DEPTH));
        pop     = (state == ST_RUN) && !halt && tick && (q_count != 3'd0);
        push    = (state == ST_RUN) && !halt && accept && (!full || pop);
    end

    snake_dir_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (halt),
        .din   (p),
        .count (q_count),
        .head  (head),
        .tail  (tail)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_WAIT;
            dir     <= DIR_RIGHT;
            moving  <= 1'b0;
            dropped <= 1'b0;
        end else begin
            dropped <= 1'b0;
            if (halt) begin
                state  <= ST_FROZEN;
                moving <= 1'b0;
            end else begin
                case (state)
                    ST_WAIT: begin
                        if (press) begin
                            if (p != opposite(dir)) begin
                                dir    <= p;
                                state  <= ST_RUN;
                                moving <= 1'b1;
                            end else begin
                                dropped <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (pop) dir <= head;
                        if (press && !push) dropped <= 1'b1;
                    end
                    default: begin
                        state <= ST_WAIT;
                        dir   <= DIR_RIGHT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb/tb_snake_dir_ctrl.sv - directed bench comparing snake_dir_ctrl against a queue-based model
module tb_snake_dir_ctrl;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       tick = 1'b0, halt = 1'b0;
    logic [1:0] dir;
    logic       moving;
    logic [2:0] q_count;
    logic       dropped;

    int vectors = 0;
    int miscompares = 0;

    // model: mode 0 = waiting for first press, 1 = running, 2 = frozen
    int m_mode, m_dir, m_drop;
    int m_q[$];

    snake_dir_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .tick(tick), .halt(halt),
        .dir(dir), .moving(moving), .q_count(q_count), .dropped(dropped)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0; m_dir = 3; m_drop = 0;
        m_q.delete();
    endtask

    task automatic model_step(input int u, input int d, input int l, input int r,
                              input int tk, input int h);
        int pr, pv, rf, popped;
        m_drop = 0;
        pv = u | d | l | r;
        pr = u ? 0 : d ? 1 : l ? 2 : 3;
        if (h) begin
            m_mode = 2;
            m_q.delete();
        end else if (m_mode == 2) begin
            m_mode = 0;
            m_dir  = 3;
        end else if (m_mode == 0) begin
            if (pv) begin
                if (pr != (m_dir ^ 1)) begin m_dir = pr; m_mode = 1; end
                else m_drop = 1;
            end
        end else begin
            rf = (m_q.size() > 0) ? m_q[$] : m_dir;
            popped = tk && (m_q.size() > 0);
            if (pv) begin
                if (pr == rf || pr == (rf ^ 1)) m_drop = 1;
                else if (m_q.size() < DEPTH || popped) m_q.push_back(pr);
                else m_drop = 1;
            end
            if (popped) m_dir = m_q.pop_front();
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("dir", int'(dir), m_dir);
        chk("moving", int'(moving), (m_mode == 1) ? 1 : 0);
        chk("q_count", int'(q_count), m_q.size());
        chk("dropped", int'(dropped), m_drop);
    end

    // Apply one cycle of inputs, advance the model with the DUT, settle past negedge.
    task automatic cyc(input int u, input int d, input int l, input int r,
                       input int tk, input int h);
        btn_up = 1'(u); btn_down = 1'(d); btn_left = 1'(l); btn_right = 1'(r);
        tick = 1'(tk); halt = 1'(h);
        @(posedge clk);
        model_step(u, d, l, r, tk, h);
        @(negedge clk);
        #1;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; tick = 0; halt = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        @(negedge clk); @(negedge clk); #1;
        reset = 1'b0;
        chk("reset_dir", int'(dir), 3);
        chk("reset_moving", int'(moving), 0);
        chk("reset_q", int'(q_count), 0);
        chk("reset_drop", int'(dropped), 0);

        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
        chk("wait_tick_dir", int'(dir), 3);
        chk("wait_tick_moving", int'(moving), 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("start_dir", int'(dir), 0);
        chk("start_moving", int'(moving), 1);

        cyc(0, 0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 1, 0);
        chk("to_right", int'(dir), 3);
        cyc(0, 1, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0);
        chk("two_queued", int'(q_count), 2);
        cyc(0, 0, 0, 0, 1, 0);
        chk("pop1_dir", int'(dir), 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("pop2_dir", int'(dir), 2);
        chk("pop2_q", int'(q_count), 0);

        cyc(1, 0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 1, 0);
        chk("to_up", int'(dir), 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("reverse_drop", int'(dropped), 1);
        chk("reverse_q", int'(q_count), 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("dup_drop", int'(dropped), 1);
        idle(1);
        chk("drop_one_cycle", int'(dropped), 0);

        cyc(0, 0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, 1, 0, 0, 0);
        chk("arb_q", int'(q_count), 1);
        chk("arb_drop", int'(dropped), 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("arb_dir", int'(dir), 0);

        cyc(0, 0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0);
        chk("full_q", int'(q_count), 2);
        cyc(0, 1, 0, 0, 0, 0);
        chk("full_drop", int'(dropped), 1);
        cyc(0, 1, 0, 0, 1, 0);
        chk("full_tick_dir", int'(dir), 0);
        chk("full_tick_q", int'(q_count), 2);
        chk("full_tick_drop", int'(dropped), 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("after_full_dir1", int'(dir), 2);
        cyc(0, 0, 0, 0, 1, 0);
        chk("tail_was_down", int'(dir), 1);

        cyc(0, 0, 0, 0, 1, 0);
        chk("empty_tick_dir", int'(dir), 1);
        cyc(0, 0, 1, 0, 1, 0);
        chk("press_tick_dir", int'(dir), 1);
        chk("press_tick_q", int'(q_count), 1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("pre_halt_q", int'(q_count), 2);
        cyc(0, 0, 0, 0, 1, 1);
        chk("halt_q", int'(q_count), 0);
        chk("halt_moving", int'(moving), 0);
        chk("halt_dir", int'(dir), 1);
        cyc(0, 1, 0, 0, 1, 1); cyc(1, 0, 0, 0, 1, 1);
        chk("frozen_dir", int'(dir), 1);
        chk("frozen_drop", int'(dropped), 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("unhalt_dir", int'(dir), 3);
        chk("unhalt_moving", int'(moving), 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("wait_reverse_drop", int'(dropped), 1);
        chk("wait_reverse_moving", int'(moving), 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("wait_dup_start", int'(moving), 1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("run_q", int'(q_count), 1);

        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_dir", int'(dir), 3);
        chk("async_moving", int'(moving), 0);
        chk("async_q", int'(q_count), 0);
        chk("async_drop", int'(dropped), 0);
        @(negedge clk); #1;
        reset = 1'b0;
        cyc(0, 0, 0, 0, 1, 0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
